cau_cmd_issuer: RTL and testbench

CAU_CMD_ISSUER -- requirements
Module: cau_cmd_issuer

---
 rtl/cau_pkg.sv | 31 +++
 rtl/cau_cmd_fifo.sv | 69 ++++++
 rtl/cau_cmd_issuer.sv | 173 +++++++++++++++++
 tb/tb_cau_cmd_issuer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cau_pkg.sv
// Shared definitions for the CAU command issuer.
// Contents: the opcode encodings, the data bus width, the queued command
// record and the issuer FSM state encoding.
package cau_pkg;

    localparam int BUS_W = 72;
    // Destination field is stored at a fixed width so that the command record
    // does not depend on N_CAU; narrower destination ports are zero-extended.
    localparam int DST_W = 8;

    typedef enum logic [1:0] {
        OP_NOOP        = 2'b00,
        OP_LOAD_SCOPE  = 2'b01,
        OP_LOAD_KERNEL = 2'b10,
        OP_CLEAR       = 2'b11
    } cau_op_e;

    typedef struct packed {
        cau_op_e          op;
        logic             bcast;
        logic [DST_W-1:0] dst;
        logic [BUS_W-1:0] data;
    } cau_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } issuer_state_e;

endpackage

// File: rtl/cau_cmd_fifo.sv
// Synchronous command FIFO with a registered occupancy count.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   push, wr_cmd    - write strobe and command; ignored while full
//   pop, rd_cmd     - read strobe and head-of-queue command (valid when !empty)
//   full, empty     - flags decoded from the registered count
// A push while full is refused even if a pop happens on the same edge.
module cau_cmd_fifo
    import cau_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  cau_cmd_t wr_cmd,
    input  logic     pop,
    output cau_cmd_t rd_cmd,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    cau_cmd_t         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rd_cmd    = mem_r[rd_ptr_r];

    // Payload storage; not reset because the pointers qualify every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_cmd;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cau_cmd_issuer.sv
// Queues host commands and issues them to a row of CAUs over a shared bus.
// Each issue occupies one ISSUE cycle followed by GAP idle cycles.
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   req_valid/req_ready         - host command handshake (accept on both high)
//   req_op/req_bcast/req_dst    - opcode, broadcast flag, target CAU index
//   req_data                    - nine packed 8-bit scope/kernel values
//   select/opcode/bus           - registered CAU-side outputs
//   busy                        - queue non-empty or FSM not idle
//   issue_cnt                   - wrapping count of commands that selected a CAU
module cau_cmd_issuer
    import cau_pkg::*;
#(
    parameter int N_CAU = 4,
    parameter int DEPTH = 4,
    parameter int GAP   = 2
)
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [1:0]                                    req_op,
    input  logic                                          req_bcast,
    input  logic [((N_CAU > 1) ? $clog2(N_CAU) : 1)-1:0] req_dst,
    input  logic [BUS_W-1:0]                              req_data,
    output logic [N_CAU-1:0]                              select,
    output logic [1:0]                                    opcode,
    output logic [BUS_W-1:0]                              bus,
    output logic                                          busy,
    output logic [15:0]                                   issue_cnt
);

    localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

    issuer_state_e    state_r;
    logic [GCW-1:0]   gap_cnt_r;
    logic [N_CAU-1:0] select_r;
    logic [1:0]       opcode_r;
    logic [BUS_W-1:0] bus_r;
    logic [15:0]      issue_cnt_r;
    logic             ready_en_r;

    cau_cmd_t         wr_cmd_s;
    cau_cmd_t         head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             gap_last_s;
    logic [N_CAU-1:0] sel_next_s;
    logic             counts_s;

    assign wr_cmd_s.op    = cau_op_e'(req_op);
    assign wr_cmd_s.bcast = req_bcast;
    assign wr_cmd_s.dst   = DST_W'(req_dst);
    assign wr_cmd_s.data  = req_data;

    // Acceptance is blocked during reset and for as long as the queue is full.
    assign req_ready  = ready_en_r && !fifo_full_s;
    assign push_s     = req_valid && req_ready;
    assign gap_last_s = (gap_cnt_r == '0);

    assign select    = select_r;
    assign opcode    = opcode_r;
    assign bus       = bus_r;
    assign issue_cnt = issue_cnt_r;
    assign busy      = !fifo_empty_s || (state_r != ST_IDLE);

    cau_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_s),
        .wr_cmd (wr_cmd_s),
        .pop    (pop_s),
        .rd_cmd (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Ready enable: low through reset, high from the first edge after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Pop decision: the head is taken from IDLE, or on the final GAP cycle so
    // back-to-back commands are spaced exactly 1+GAP cycles apart.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_last_s && !fifo_empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Select decode for the head command. An out-of-range destination matches
    // no CAU and yields an all-zero select; NOOP never selects anything.
    always_comb begin
        sel_next_s = '0;
        if (head_s.op == OP_NOOP) begin
            sel_next_s = '0;
        end else if (head_s.bcast) begin
            sel_next_s = '1;
        end else begin
            for (int i = 0; i < N_CAU; i++) begin
                sel_next_s[i] = (head_s.dst == DST_W'(i));
            end
        end
        counts_s = |sel_next_s;
    end

    // Issuer FSM with registered CAU outputs. The bus keeps its last value
    // outside ISSUE; select and opcode return to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gap_cnt_r   <= '0;
            select_r    <= '0;
            opcode_r    <= 2'b00;
            bus_r       <= '0;
            issue_cnt_r <= 16'd0;
        end else if (pop_s) begin
            state_r  <= ST_ISSUE;
            select_r <= sel_next_s;
            opcode_r <= head_s.op;
            bus_r    <= head_s.data;
            if (counts_s) begin
                issue_cnt_r <= issue_cnt_r + 16'd1;
            end
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    state_r   <= ST_GAP;
                    select_r  <= '0;
                    opcode_r  <= 2'b00;
                    gap_cnt_r <= GCW'(GAP - 1);
                end
                ST_GAP: begin
                    if (gap_last_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GCW'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    select_r <= '0;
                    opcode_r <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cau_cmd_issuer.sv
// Scoreboard bench for cau_cmd_issuer. Five CAUs are instantiated so that
// destinations 5..7 are encodable and exercise the out-of-range path.
// The reference model schedules each accepted command at
// max(accept_edge + 1, previous_issue + 1 + GAP) and derives queue occupancy,
// busy and ready from that schedule.
module tb_cau_cmd_issuer;

    localparam int N_CAU = 5;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic        req_bcast = 1'b0;
    logic [2:0]  req_dst = 3'd0;
    logic [71:0] req_data = 72'd0;
    logic        req_ready;
    logic [4:0]  select;
    logic [1:0]  opcode;
    logic [71:0] bus;
    logic        busy;
    logic [15:0] issue_cnt;

    typedef struct {
        int          issue;
        logic [4:0]  sel;
        logic [1:0]  op;
        logic [71:0] data;
        bit          counts;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          rst_last = 0;
    int          sched_last = -100;
    int          last_issue = -100;
    logic [71:0] bus_m = 72'd0;
    logic [15:0] cnt_m = 16'd0;
    int          checks = 0;
    int          failures = 0;
    bit          check_en = 1'b0;

    cau_cmd_issuer #(.N_CAU(N_CAU), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_bcast (req_bcast),
        .req_dst   (req_dst),
        .req_data  (req_data),
        .select    (select),
        .opcode    (opcode),
        .bus       (bus),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    // Edge counter and record of the last edge that sampled reset high.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) rst_last = cyc;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int occupancy();
        int n = 0;
        foreach (q[i]) if (q[i].issue > cyc) n++;
        return n;
    endfunction

    function automatic logic [71:0] rand72();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Monitor: each cycle the DUT either presents the scheduled command or idles.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [4:0] es;
        logic [1:0] eo;
        bit         bsy;
        if (check_en) begin
            es = 5'd0;
            eo = 2'b00;
            if (q.size() > 0 && q[0].issue == cyc) begin
                e = q.pop_front();
                es = e.sel;
                eo = e.op;
                bus_m = e.data;
                if (e.counts) cnt_m = cnt_m + 16'd1;
                last_issue = cyc;
            end
            bsy = (q.size() > 0) || (cyc >= last_issue && cyc < last_issue + 1 + GAP);
            chk("select", 72'(select), 72'(es));
            chk("opcode", 72'(opcode), 72'(eo));
            chk("bus", bus, bus_m);
            chk("issue_cnt", 72'(issue_cnt), 72'(cnt_m));
            chk("busy", 72'(busy), 72'(bsy));
        end
    end

    task automatic send(input logic [1:0] op, input logic bc, input logic [2:0] dst,
                        input logic [71:0] data);
        bit   done = 1'b0;
        int   tries = 0;
        bit   rdy;
        exp_t e;
        while (!done) begin
            @(negedge clk); #1;
            req_valid = 1'b1;
            req_op    = op;
            req_bcast = bc;
            req_dst   = dst;
            req_data  = data;
            rdy = (cyc > rst_last) && (occupancy() < DEPTH);
            chk("req_ready", 72'(req_ready), 72'(rdy));
            if (rdy) begin
                e.issue  = (cyc + 2 > sched_last + 1 + GAP) ? cyc + 2 : sched_last + 1 + GAP;
                e.op     = op;
                e.data   = data;
                e.counts = (op != 2'b00) && (bc || (int'(dst) < N_CAU));
                if (op == 2'b00)            e.sel = 5'd0;
                else if (bc)                e.sel = 5'b11111;
                else if (int'(dst) < N_CAU) e.sel = 5'(1) << dst;
                else                        e.sel = 5'd0;
                sched_last = e.issue;
                q.push_back(e);
                done = 1'b1;
            end else if (++tries > 40) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout cyc=%0d actual=not_ready expected=accept", cyc);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst = 1'b1;
        req_valid = 1'b0;
        q.delete();
        sched_last = -100;
        last_issue = -100;
        bus_m = 72'd0;
        cnt_m = 16'd0;
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_en = 1'b1;
        idle(2);
        @(negedge clk); #1;
        chk("ready_in_reset", 72'(req_ready), 72'd0);
        rst = 1'b0;
        idle(2);

        // Single LOAD SCOPE to CAU 2.
        send(2'b01, 1'b0, 3'd2, 72'h010203040506070809);
        idle(6);
        // Broadcast CLEAR.
        send(2'b11, 1'b1, 3'd0, rand72());
        idle(5);
        // Back-to-back burst deep enough to fill the queue.
        for (int i = 0; i < 8; i++) send(2'b10, 1'b0, 3'($urandom_range(0, 4)), rand72());
        idle(30);
        // Silent slots: NOOP and out-of-range destinations.
        send(2'b00, 1'b1, 3'd1, rand72());
        send(2'b01, 1'b0, 3'd5, rand72());
        send(2'b11, 1'b0, 3'd7, rand72());
        idle(12);
        // Counter wrap from 65535.
        @(negedge clk); #1;
        force dut.issue_cnt_r = 16'hFFFF;
        cnt_m = 16'hFFFF;
        @(negedge clk); #1;
        release dut.issue_cnt_r;
        idle(2);
        send(2'b10, 1'b0, 3'd0, rand72());
        idle(5);
        // Reset while in GAP with several commands queued.
        for (int i = 0; i < 6; i++) send(2'b01, 1'b1, 3'd0, rand72());
        do_reset(1);
        idle(10);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            send(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)), rand72());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
            if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 3));
        end
        idle(20);
        chk("drained", 72'(q.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
